trace_line_arbiter: RTL and testbench
=====================================

// Module: trace_line_arbiter
// PURPOSE
//  Shares one cpu_checker-style trace format checker between two CPU trace
//  character sources. Grants whole lines ('^' .. '#') to one source at a time
//  (round-robin), streams them contiguously into the checker, then captures the
//  checker's format_type verdict per line. Sits between trace sources and checker.
// PARAMETERS
//  MAX_LINE_LEN  64  max chars per line incl. '^' and '#'; longer lines abort
// PORTS
//  clk              in   1  clock
//  reset            in   1  reset, synchronous, active-high
//  src0_valid       in   1  source 0 presents src0_char
//  src0_char        in   8  source 0 ASCII char
//  src0_ready       out  1  source 0 char consumed this cycle (valid&ready)
//  src1_valid       in   1  source 1 presents src1_char
//  src1_char        in   8  source 1 ASCII char
//  src1_ready       out  1  source 1 char consumed this cycle
//  chk_char         out  8  registered char driven to checker (0x00 when idle)
//  chk_format_type  in   2  checker verdict (0 invalid, 1 reg-write, 2 mem-write)
//  res_valid        out  1  1-cycle pulse: line verdict available
//  res_src          out  1  source of reported/aborted line
//  res_type         out  2  captured chk_format_type
//  abort            out  1  1-cycle pulse: line aborted (stall or overlength)
//  bad_cnt          out 16  saturating count of res_type==0 results
// BEHAVIOUR
//  - Reset: state IDLE, chk_char=0x00, res_valid=0, res_src=0, res_type=0,
//    abort=0, bad_cnt=0, len=0, last_grant=1 (src0 wins first tie). Reset
//    mid-line drops the line silently: no res_valid, no abort.
//  - States: IDLE, STREAM, DRAIN, RESULT, FLUSH.
//  - IDLE: source "starting" = valid & char=='^'. If one starts it wins; if both,
//    winner = source != last_grant. Winner: ready=1, chk_char<='^', len<=1,
//    -> STREAM. Loser held (ready=0). Non-'^' valid chars are discarded:
//    ready=1, never forwarded. chk_char<=0x00 otherwise.
//  - STREAM (granted g): only g may get ready; other ready=0.
//    g valid: ready=1, chk_char<=char, len++. Char=='#' -> DRAIN.
//    Accepting a char that makes len > MAX_LINE_LEN (not '#'): abort pulse,
//    chk_char<=0x00, -> FLUSH. g not valid (stall): abort pulse,
//    chk_char<=0x00, -> IDLE. Any abort sets last_grant<=g, res_src<=g.
//  - DRAIN: chk_char<=0x00 (checker consumes '#' on this edge) -> RESULT.
//  - RESULT: res_valid<=1, res_type<=chk_format_type, res_src<=g,
//    last_grant<=g, bad_cnt+=(type==0) saturating at 0xFFFF -> IDLE.
//    Latency: '#' accepted at edge N -> res_valid high during cycle after N+2.
//  - FLUSH: g ready=1, chars discarded; on consuming '#' or g not valid -> IDLE.
//  - IDLE grant allowed in same cycle res_valid pulses (back-to-back lines).
//  - ready is combinational from state, valid, char; all other outputs registered.
// TESTING
//  1. src0 streams "^1000@00003000: $ 1 <= 0000000a#" -> chk_char = stream 1
//     cycle late, one res_valid, res_src=0, res_type=1, abort never.
//  2. After reset both present '^' same cycle -> src0 granted, src1_ready=0
//     until src0 line ends; src1 line follows; res_src 0 then 1.
//  3. src0 "^10" then valid=0 one cycle -> abort pulse, res_src=0, chk_char
//     0x00, no res_valid; next src0 '^' restarts cleanly.
//  4. MAX_LINE_LEN=8, 12-char line then '#' -> abort on 9th char, remaining
//     chars incl. '#' consumed with ready=1, none forwarded, no res_valid.
//  5. src1 "xyz^..." -> x,y,z consumed, chk_char stays 0x00 until '^';
//     malformed line -> res_type=0, bad_cnt=1.
//  6. reset high mid STREAM -> next cycle all outputs at reset values, no
//     res_valid/abort for the interrupted line.

Source files
------------

// File: rtl/trace_line_arbiter.sv
// trace_line_arbiter: round-robin line arbiter feeding two trace character sources
// into one shared format checker and capturing its per-line verdict.
module trace_line_arbiter #(
    parameter int MAX_LINE_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        src0_valid,
    input  logic [7:0]  src0_char,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [7:0]  src1_char,
    output logic        src1_ready,
    output logic [7:0]  chk_char,
    input  logic [1:0]  chk_format_type,
    output logic        res_valid,
    output logic        res_src,
    output logic [1:0]  res_type,
    output logic        abort,
    output logic [15:0] bad_cnt
);
    localparam int LW = $clog2(MAX_LINE_LEN + 2);
    localparam logic [7:0] CARET = 8'h5E;
    localparam logic [7:0] HASH  = 8'h23;

    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, RESULT, FLUSH} state_t;

    state_t        state_q, state_d;
    logic          g_q, g_d, last_q, last_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    chk_char_q, chk_char_d;
    logic          res_valid_q, res_valid_d, res_src_q, res_src_d, abort_q, abort_d;
    logic [1:0]    res_type_q, res_type_d;
    logic [15:0]   bad_cnt_q, bad_cnt_d;
    logic          start0, start1, win, g_valid;
    logic [7:0]    g_char;

    assign start0  = src0_valid && src0_char == CARET;
    assign start1  = src1_valid && src1_char == CARET;
    // on a tie the source that did not own the previous line wins
    assign win     = (start0 && start1) ? ~last_q : start1;
    assign g_valid = g_q ? src1_valid : src0_valid;
    assign g_char  = g_q ? src1_char : src0_char;

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        last_d      = last_q;
        len_d       = len_q;
        chk_char_d  = 8'h00;
        res_valid_d = 1'b0;
        res_src_d   = res_src_q;
        res_type_d  = res_type_q;
        abort_d     = 1'b0;
        bad_cnt_d   = bad_cnt_q;
        src0_ready  = 1'b0;
        src1_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                src0_ready = src0_valid && !(start0 && win);
                src1_ready = src1_valid && !(start1 && !win);
                if (start0 || start1) begin
                    g_d        = win;
                    chk_char_d = CARET;
                    len_d      = LW'(1);
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                src0_ready = g_valid && !g_q;
                src1_ready = g_valid && g_q;
                if (g_valid && g_char == HASH) begin
                    chk_char_d = g_char;
                    len_d      = len_q + LW'(1);
                    state_d    = DRAIN;
                end else if (g_valid && len_q < LW'(MAX_LINE_LEN)) begin
                    chk_char_d = g_char;
                    len_d      = len_q + LW'(1);
                end else begin
                    abort_d   = 1'b1;
                    last_d    = g_q;
                    res_src_d = g_q;
                    state_d   = g_valid ? FLUSH : IDLE;
                end
            end
            DRAIN: state_d = RESULT;
            RESULT: begin
                res_valid_d = 1'b1;
                res_type_d  = chk_format_type;
                res_src_d   = g_q;
                last_d      = g_q;
                bad_cnt_d   = bad_cnt_q + {15'd0, chk_format_type == 2'd0 && bad_cnt_q != 16'hFFFF};
                state_d     = IDLE;
            end
            FLUSH: begin
                src0_ready = g_valid && !g_q;
                src1_ready = g_valid && g_q;
                if (!g_valid || g_char == HASH) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            g_q         <= 1'b0;
            last_q      <= 1'b1;
            len_q       <= '0;
            chk_char_q  <= 8'h00;
            res_valid_q <= 1'b0;
            res_src_q   <= 1'b0;
            res_type_q  <= 2'd0;
            abort_q     <= 1'b0;
            bad_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            last_q      <= last_d;
            len_q       <= len_d;
            chk_char_q  <= chk_char_d;
            res_valid_q <= res_valid_d;
            res_src_q   <= res_src_d;
            res_type_q  <= res_type_d;
            abort_q     <= abort_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign chk_char  = chk_char_q;
    assign res_valid = res_valid_q;
    assign res_src   = res_src_q;
    assign res_type  = res_type_q;
    assign abort     = abort_q;
    assign bad_cnt   = bad_cnt_q;
endmodule

// File: tb/tb_trace_line_arbiter.sv
// tb_trace_line_arbiter: random trace sources and a toy checker against a
// line-level reference model of the arbiter.
module tb_trace_line_arbiter;
    localparam int MAX = 8;

    logic        clk = 1'b0, reset;
    logic        src0_valid, src0_ready, src1_valid, src1_ready;
    logic [7:0]  src0_char, src1_char, chk_char;
    logic [1:0]  chk_format_type, res_type;
    logic        res_valid, res_src, abort;
    logic [15:0] bad_cnt;

    trace_line_arbiter #(.MAX_LINE_LEN(MAX)) dut (
        .clk(clk), .reset(reset),
        .src0_valid(src0_valid), .src0_char(src0_char), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_char(src1_char), .src1_ready(src1_ready),
        .chk_char(chk_char), .chk_format_type(chk_format_type),
        .res_valid(res_valid), .res_src(res_src), .res_type(res_type),
        .abort(abort), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // sources: pending characters per source
    logic [7:0] sq[2][$];
    bit         v[2], r[2];
    logic [7:0] c[2];
    string      pool = "0123 $*@:<=a";
    string      junk = "xyz01@";

    task automatic refill(input int i);
        int n;
        if (sq[i].size() != 0) return;
        if ($urandom_range(0, 3) == 0) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) sq[i].push_back(junk[$urandom_range(0, junk.len() - 1)]);
        end else begin
            n = $urandom_range(1, 10);
            sq[i].push_back(8'h5E);
            for (int k = 0; k < n; k++) sq[i].push_back(pool[$urandom_range(0, pool.len() - 1)]);
            sq[i].push_back(8'h23);
        end
    endtask

    // toy format checker: '$' in line -> reg-write, '*' -> mem-write, else invalid
    bit         ck_dollar, ck_star;
    logic [1:0] ck_next = 2'd0;

    task automatic ck_step(input logic [7:0] ch);
        if (ch == 8'h5E) begin ck_dollar = 0; ck_star = 0; end
        else if (ch == 8'h23) ck_next = ck_dollar ? 2'd1 : ck_star ? 2'd2 : 2'd0;
        else if (ch == 8'h24) ck_dollar = 1;
        else if (ch == 8'h2A) ck_star = 1;
    endtask

    // reference model: which source owns the checker and what that line holds
    int         mode, own, last, waitn, exp_bad;
    logic [7:0] line[$];
    logic [7:0] exp_chk;
    bit         exp_rv, exp_rs, exp_ab;
    logic [1:0] exp_rt;

    function automatic logic [1:0] verdict();
        bit d = 0, s = 0;
        foreach (line[k]) begin
            if (line[k] == 8'h24) d = 1;
            if (line[k] == 8'h2A) s = 1;
        end
        return d ? 2'd1 : s ? 2'd2 : 2'd0;
    endfunction

    task automatic m_reset();
        mode = 0; own = 0; last = 1; waitn = 0; exp_bad = 0;
        exp_chk = 8'h00; exp_rv = 0; exp_rs = 0; exp_ab = 0; exp_rt = 2'd0;
        line.delete();
    endtask

    task automatic m_abort();
        exp_ab = 1; exp_rs = own[0]; last = own;
    endtask

    task automatic m_step();
        bit st[2];
        int w;
        r[0] = 0; r[1] = 0;
        exp_rv = 0; exp_ab = 0; exp_chk = 8'h00;
        case (mode)
            0: begin
                for (int i = 0; i < 2; i++) st[i] = v[i] && c[i] == 8'h5E;
                w = (st[0] && st[1]) ? 1 - last : (st[1] ? 1 : 0);
                for (int i = 0; i < 2; i++) r[i] = v[i] && !(st[i] && w != i);
                if (st[0] || st[1]) begin
                    own = w; line.delete(); line.push_back(8'h5E); exp_chk = 8'h5E; mode = 1;
                end
            end
            1: if (!v[own]) begin m_abort(); mode = 0; end
               else begin
                   r[own] = 1;
                   line.push_back(c[own]);
                   if (c[own] == 8'h23) begin exp_chk = c[own]; mode = 2; waitn = 2; end
                   else if (line.size() > MAX) begin m_abort(); mode = 3; end
                   else exp_chk = c[own];
               end
            2: begin
                waitn--;
                if (waitn == 0) begin
                    exp_rv = 1; exp_rt = verdict(); exp_rs = own[0]; last = own;
                    if (exp_rt == 2'd0 && exp_bad < 65535) exp_bad++;
                    mode = 0;
                end
            end
            default: begin
                r[own] = v[own];
                if (!v[own] || c[own] == 8'h23) mode = 0;
            end
        endcase
    endtask

    initial begin
        reset = 1; src0_valid = 0; src1_valid = 0; src0_char = 0; src1_char = 0;
        chk_format_type = 2'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_chk_char", chk_char, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_src", res_src, 0);
        check("rst_res_type", res_type, 0);
        check("rst_abort", abort, 0);
        check("rst_bad_cnt", bad_cnt, 0);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            ck_step(chk_char);
            reset = cyc > 10 && ($urandom_range(0, 299) == 0 || cyc == 2500);
            for (int i = 0; i < 2; i++) begin
                refill(i);
                v[i] = $urandom_range(0, 29) != 0;
                c[i] = v[i] ? sq[i][0] : 8'h00;
            end
            src0_valid = v[0]; src0_char = c[0];
            src1_valid = v[1]; src1_char = c[1];
            #1;
            if (reset) m_reset();
            else begin
                m_step();
                check("src0_ready", src0_ready, r[0]);
                check("src1_ready", src1_ready, r[1]);
                for (int i = 0; i < 2; i++) if (r[i]) void'(sq[i].pop_front());
            end
            @(posedge clk);
            #1;
            chk_format_type = ck_next;
            check("chk_char", chk_char, exp_chk);
            check("res_valid", res_valid, exp_rv);
            check("abort", abort, exp_ab);
            check("res_src", res_src, exp_rs);
            check("res_type", res_type, exp_rt);
            check("bad_cnt", bad_cnt, exp_bad);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
